// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared state type, default ROM image and one-hot check for onehot_rom_streamer
package rom_stream_pkg;
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [63:0] DEFAULT_ROM_INIT = 64'hB64AD97E2BF15CA3;
  function automatic bit is_onehot(input logic [63:0] vec);
    return (vec != '0) && ((vec & (vec - 64'd1)) == '0);
  endfunction
endpackage

// File: rtl/onehot_to_idx.sv
// onehot_to_idx: one-hot vector to binary index, valid when exactly one bit is set
module onehot_to_idx
  import rom_stream_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < DEPTH; i++) if (vec[i]) idx = IW'(i);
    valid = is_onehot(64'(vec));
  end
endmodule

// File: rtl/onehot_rom_streamer.sv
// onehot_rom_streamer: one-hot addressed ROM burst reader streaming words on valid/ready, wrapping modulo DEPTH
module onehot_rom_streamer
  import rom_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int LEN_W = $clog2(DEPTH) + 1,
  parameter logic [DEPTH*DATA_W-1:0] ROM_INIT = DEFAULT_ROM_INIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DEPTH-1:0]  req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err
);
  localparam int IW = $clog2(DEPTH);
  state_t            state_q;
  logic [IW-1:0]     idx_q, idx_d, a_idx;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, last_q, err_q, a_ok, legal;
  logic [DATA_W-1:0] rom [DEPTH];
  onehot_to_idx #(.DEPTH(DEPTH)) u_dec (.vec(req_addr), .idx(a_idx), .valid(a_ok));
  always_comb begin
    for (int i = 0; i < DEPTH; i++) rom[i] = ROM_INIT[i*DATA_W +: DATA_W];
    idx_d = (idx_q == IW'(DEPTH - 1)) ? '0 : idx_q + IW'(1);
    legal = a_ok && (req_len != '0) && (req_len <= LEN_W'(DEPTH));
  end
  assign req_ready = rst_n && enable && (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign err       = err_q;
  // abort (enable low) and final-beat transfer share the same clear-to-idle path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (req_valid && req_ready && legal) begin
          state_q <= STREAM;
          idx_q   <= a_idx;
          rem_q   <= req_len;
          data_q  <= rom[a_idx];
          valid_q <= 1'b1;
          last_q  <= (req_len == LEN_W'(1));
        end else if (req_valid && req_ready) begin
          err_q <= 1'b1;
        end
      end else if (!enable || (out_ready && last_q)) begin
        state_q <= IDLE;
        data_q  <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (out_ready) begin
        idx_q  <= idx_d;
        rem_q  <= rem_q - LEN_W'(1);
        data_q <= rom[idx_d];
        last_q <= (rem_q == LEN_W'(2));
      end
    end
  end
endmodule

// File: tb/tb_onehot_rom_streamer.sv
// tb_onehot_rom_streamer: directed vectors with hand-computed ROM words for onehot_rom_streamer
module tb_onehot_rom_streamer;
  logic       clk, rst_n, enable, req_valid, req_ready, out_valid, out_ready, out_last, err;
  logic [7:0] req_addr, out_data;
  logic [3:0] req_len;
  int vectors = 0, miscompares = 0;
  onehot_rom_streamer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
    chk({tag, ".valid"}, 8'(out_valid), 8'(v));
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".last"}, 8'(out_last), 8'(l));
    chk({tag, ".err"}, 8'(err), 8'd0);
  endtask
  task automatic req(input logic [7:0] a, input logic [3:0] l);
    req_valid = 1'b1;
    req_addr = a;
    req_len = l;
  endtask
  initial begin
    rst_n = 1'b0; enable = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    #1;
    chk("rst_ready", 8'(req_ready), 8'd0);
    step(); step();
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    enable = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_dis_ready", 8'(req_ready), 8'd0);
    enable = 1'b1;
    #1;
    chk("idle_en_ready", 8'(req_ready), 8'd1);
    // single read
    req(8'h04, 4'd1);
    step();
    chk_out("single", 1'b1, 8'hF1, 1'b1);
    chk("single_busy_ready", 8'(req_ready), 8'd0);
    req_valid = 1'b0;
    step();
    chk_out("single_end", 1'b0, 8'h00, 1'b0);
    chk("single_end_ready", 8'(req_ready), 8'd1);
    // wrapping burst
    req(8'h40, 4'd4);
    step();
    chk_out("wrap0", 1'b1, 8'h4A, 1'b0);
    req_valid = 1'b0;
    step();
    chk_out("wrap1", 1'b1, 8'hB6, 1'b0);
    step();
    chk_out("wrap2", 1'b1, 8'hA3, 1'b0);
    step();
    chk_out("wrap3", 1'b1, 8'h5C, 1'b1);
    step();
    chk_out("wrap_end", 1'b0, 8'h00, 1'b0);
    // backpressure
    req(8'h01, 4'd3);
    step();
    chk_out("bp0", 1'b1, 8'hA3, 1'b0);
    req_valid = 1'b0;
    out_ready = 1'b0;
    step();
    chk_out("bp_hold1", 1'b1, 8'hA3, 1'b0);
    step();
    chk_out("bp_hold2", 1'b1, 8'hA3, 1'b0);
    step();
    chk_out("bp_hold3", 1'b1, 8'hA3, 1'b0);
    out_ready = 1'b1;
    step();
    chk_out("bp1", 1'b1, 8'h5C, 1'b0);
    step();
    chk_out("bp2", 1'b1, 8'hF1, 1'b1);
    step();
    chk_out("bp_end", 1'b0, 8'h00, 1'b0);
    // illegal requests
    req(8'h05, 4'd2);
    step();
    chk("ill_multi_err", 8'(err), 8'd1);
    chk("ill_multi_valid", 8'(out_valid), 8'd0);
    req(8'h00, 4'd1);
    step();
    chk("ill_zero_err", 8'(err), 8'd1);
    chk("ill_zero_valid", 8'(out_valid), 8'd0);
    req(8'h02, 4'd0);
    step();
    chk("ill_len0_err", 8'(err), 8'd1);
    chk("ill_len0_valid", 8'(out_valid), 8'd0);
    req(8'h02, 4'd9);
    step();
    chk("ill_len9_err", 8'(err), 8'd1);
    chk("ill_len9_valid", 8'(out_valid), 8'd0);
    req_valid = 1'b0;
    step();
    chk_out("ill_end", 1'b0, 8'h00, 1'b0);
    // enable abort, with out_ready high at the same time
    req(8'h02, 4'd8);
    step();
    chk_out("ab0", 1'b1, 8'h5C, 1'b0);
    req_valid = 1'b0;
    step();
    chk_out("ab1", 1'b1, 8'hF1, 1'b0);
    enable = 1'b0;
    step();
    chk_out("ab_drop", 1'b0, 8'h00, 1'b0);
    chk("ab_ready", 8'(req_ready), 8'd0);
    // requests ignored while disabled in IDLE
    req(8'h01, 4'd1);
    step();
    chk_out("dis_idle", 1'b0, 8'h00, 1'b0);
    enable = 1'b1;
    req(8'h02, 4'd1);
    step();
    chk_out("re_en", 1'b1, 8'h5C, 1'b1);
    req_valid = 1'b0;
    step();
    chk_out("re_en_end", 1'b0, 8'h00, 1'b0);
    // asynchronous reset mid-burst
    req(8'h08, 4'd4);
    step();
    chk_out("rb0", 1'b1, 8'h2B, 1'b0);
    req_valid = 1'b0;
    step();
    chk_out("rb1", 1'b1, 8'h7E, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rb_async", 1'b0, 8'h00, 1'b0);
    chk("rb_ready", 8'(req_ready), 8'd0);
    step();
    rst_n = 1'b1;
    req(8'h10, 4'd1);
    step();
    chk_out("post_rst", 1'b1, 8'h7E, 1'b1);
    req_valid = 1'b0;
    step();
    chk_out("post_rst_end", 1'b0, 8'h00, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
